// File: rtl/timing_loop_ctrl.sv
// Acquisition/tracking sequencer for the QPSK symbol timing loop.
// Selects loop-filter gains, flushes/holds the loop and reports lock state.
module timing_loop_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int ACQ_SYMS      = 256,
  parameter int LOCK_THRESH   = 1024,
  parameter int UNLOCK_THRESH = 4096,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_COUNT  = 32,
  parameter int TIMEOUT_SYMS  = 4096,
  parameter int FLUSH_CYC     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         strobe,
  input  logic signed [DATA_WIDTH-1:0] e_k,
  output logic [1:0]                   gain_sel,
  output logic                         loop_rst,
  output logic                         loop_hold,
  output logic                         locked,
  output logic                         lock_lost,
  output logic [7:0]                   retry_cnt,
  output logic [2:0]                   state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FLUSH  = 3'd1;
  localparam logic [2:0] ACQ    = 3'd2;
  localparam logic [2:0] TRACK  = 3'd3;
  localparam logic [2:0] LOCKED = 3'd4;

  localparam int FL_W  = $clog2(FLUSH_CYC) + 1;
  localparam int ACQ_W = $clog2(ACQ_SYMS) + 1;
  localparam int GD_W  = $clog2(LOCK_COUNT) + 1;
  localparam int BD_W  = $clog2(UNLOCK_COUNT) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_SYMS) + 1;

  localparam logic [FL_W-1:0]  FLUSH_LAST  = FL_W'(FLUSH_CYC - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST    = ACQ_W'(ACQ_SYMS - 1);
  localparam logic [GD_W-1:0]  GOOD_LAST   = GD_W'(LOCK_COUNT - 1);
  localparam logic [BD_W-1:0]  BAD_LAST    = BD_W'(UNLOCK_COUNT - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_SYMS - 1);
  localparam logic [DATA_WIDTH-1:0] LOCK_T   = DATA_WIDTH'(LOCK_THRESH);
  localparam logic [DATA_WIDTH-1:0] UNLOCK_T = DATA_WIDTH'(UNLOCK_THRESH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [2:0]            state_reg, state_next;
  logic [FL_W-1:0]       flush_cnt_reg, flush_cnt_next;
  logic [ACQ_W-1:0]      acq_cnt_reg, acq_cnt_next;
  logic [GD_W-1:0]       good_cnt_reg, good_cnt_next;
  logic [BD_W-1:0]       bad_cnt_reg, bad_cnt_next;
  logic [TO_W-1:0]       timeout_cnt_reg, timeout_cnt_next;
  logic [7:0]            retry_reg, retry_next;
  logic                  lock_lost_reg, lock_lost_next;
  logic [DATA_WIDTH-1:0] e_raw, e_mag;
  logic                  e_good, e_bad;

  // Negating the most-negative value overflows, so clamp it to the largest positive.
  assign e_raw = e_k;
  always_comb begin
    e_mag = e_raw;
    if (e_raw == MOST_NEG)
      e_mag = MOST_POS;
    else if (e_raw[DATA_WIDTH-1])
      e_mag = -e_raw;
  end

  assign e_good = (e_mag < LOCK_T);
  assign e_bad  = (e_mag >= UNLOCK_T);

  always_comb begin
    state_next       = state_reg;
    flush_cnt_next   = flush_cnt_reg;
    acq_cnt_next     = acq_cnt_reg;
    good_cnt_next    = good_cnt_reg;
    bad_cnt_next     = bad_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    retry_next       = retry_reg;
    lock_lost_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          state_next   = ACQ;
          acq_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      ACQ: begin
        if (strobe) begin
          if (acq_cnt_reg == ACQ_LAST) begin
            state_next       = TRACK;
            good_cnt_next    = '0;
            timeout_cnt_next = '0;
          end else begin
            acq_cnt_next = acq_cnt_reg + 1'b1;
          end
        end
      end
      TRACK: begin
        // Reaching lock wins over a timeout landing on the same strobe.
        if (strobe) begin
          if (e_good && good_cnt_reg == GOOD_LAST) begin
            state_next   = LOCKED;
            bad_cnt_next = '0;
          end else if (timeout_cnt_reg == TO_LAST) begin
            state_next     = FLUSH;
            flush_cnt_next = '0;
            if (retry_reg != 8'hFF)
              retry_next = retry_reg + 8'd1;
          end else begin
            good_cnt_next    = e_good ? good_cnt_reg + 1'b1 : '0;
            timeout_cnt_next = timeout_cnt_reg + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (strobe) begin
          if (!e_bad) begin
            bad_cnt_next = '0;
          end else if (bad_cnt_reg == BAD_LAST) begin
            state_next     = FLUSH;
            flush_cnt_next = '0;
            lock_lost_next = 1'b1;
          end else begin
            bad_cnt_next = bad_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Dropping enable aborts everything except the retry history.
    if (!enable) begin
      state_next       = IDLE;
      flush_cnt_next   = '0;
      acq_cnt_next     = '0;
      good_cnt_next    = '0;
      bad_cnt_next     = '0;
      timeout_cnt_next = '0;
      lock_lost_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      flush_cnt_reg   <= '0;
      acq_cnt_reg     <= '0;
      good_cnt_reg    <= '0;
      bad_cnt_reg     <= '0;
      timeout_cnt_reg <= '0;
      retry_reg       <= '0;
      lock_lost_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      flush_cnt_reg   <= flush_cnt_next;
      acq_cnt_reg     <= acq_cnt_next;
      good_cnt_reg    <= good_cnt_next;
      bad_cnt_reg     <= bad_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      retry_reg       <= retry_next;
      lock_lost_reg   <= lock_lost_next;
    end
  end

  always_comb begin
    gain_sel  = 2'd0;
    loop_rst  = 1'b0;
    loop_hold = 1'b0;
    locked    = 1'b0;
    case (state_reg)
      IDLE:   loop_hold = 1'b1;
      FLUSH: begin
        loop_rst  = 1'b1;
        loop_hold = 1'b1;
        gain_sel  = 2'd2;
      end
      ACQ:    gain_sel = 2'd2;
      TRACK:  gain_sel = 2'd1;
      LOCKED: locked = 1'b1;
      default: loop_hold = 1'b1;
    endcase
  end

  assign lock_lost = lock_lost_reg;
  assign retry_cnt = retry_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Directed bench for timing_loop_ctrl: expected outputs are queued with each
// stimulus step and popped for comparison once the clock edge has been applied.
module tb_timing_loop_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FLUSH  = 3'd1;
  localparam logic [2:0] S_ACQ    = 3'd2;
  localparam logic [2:0] S_TRACK  = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               strobe = 1'b0;
  logic signed [15:0] e_k = '0;
  logic [1:0]         gain_sel;
  logic               loop_rst, loop_hold, locked, lock_lost;
  logic [7:0]         retry_cnt;
  logic [2:0]         state;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] rc;
    logic       lost;
  } exp_t;

  exp_t sb_q[$];

  timing_loop_ctrl #(
    .DATA_WIDTH(16), .ACQ_SYMS(16), .LOCK_THRESH(1024), .UNLOCK_THRESH(4096),
    .LOCK_COUNT(8), .UNLOCK_COUNT(4), .TIMEOUT_SYMS(64), .FLUSH_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .strobe(strobe), .e_k(e_k),
    .gain_sel(gain_sel), .loop_rst(loop_rst), .loop_hold(loop_hold),
    .locked(locked), .lock_lost(lock_lost), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    assert (act === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp_v);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    logic [1:0] g;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: scoreboard empty observed=%0d expected=entry", tag, sb_q.size());
      return;
    end
    e = sb_q.pop_front();
    g = (e.st == S_FLUSH || e.st == S_ACQ) ? 2'd2 : (e.st == S_TRACK) ? 2'd1 : 2'd0;
    cmp({tag, ".state"},     32'(state),     32'(e.st));
    cmp({tag, ".gain_sel"},  32'(gain_sel),  32'(g));
    cmp({tag, ".loop_rst"},  32'(loop_rst),  32'(e.st == S_FLUSH));
    cmp({tag, ".loop_hold"}, 32'(loop_hold), 32'(e.st == S_IDLE || e.st == S_FLUSH));
    cmp({tag, ".locked"},    32'(locked),    32'(e.st == S_LOCKED));
    cmp({tag, ".lock_lost"}, 32'(lock_lost), 32'(e.lost));
    cmp({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(e.rc));
  endtask

  // One clock: drive, queue expectation, apply edge, compare after the edge.
  task automatic step(input logic stb, input logic [15:0] e, input logic [2:0] st,
                      input logic [7:0] rc, input logic lost, input string tag);
    exp_t x;
    x.st = st;
    x.rc = rc;
    x.lost = lost;
    sb_q.push_back(x);
    strobe = stb;
    e_k = e;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    e_k = '0;
    check(tag);
  endtask

  task automatic sym(input logic [15:0] e, input logic [2:0] st, input logic [7:0] rc,
                     input logic lost, input int gap, input string tag);
    step(1'b1, e, st, rc, lost, tag);
    for (int k = 1; k < gap; k++) step(1'b0, 16'd0, st, rc, 1'b0, tag);
  endtask

  // Finish the 4-cycle flush, then run the 16-strobe acquisition into TRACK.
  task automatic enter_track(input logic [7:0] rc, input int gap, input int flush_seen);
    for (int k = flush_seen; k < 4; k++) step(1'b0, 16'd0, S_FLUSH, rc, 1'b0, "flush");
    step(1'b0, 16'd0, S_ACQ, rc, 1'b0, "acq_entry");
    for (int k = 0; k < 15; k++) sym(16'd0, S_ACQ, rc, 1'b0, gap, "acq");
    sym(16'd0, S_TRACK, rc, 1'b0, gap, "acq_done");
  endtask

  initial begin
    logic [7:0] rc;

    // Reset state
    step(1'b0, 16'd0, S_IDLE, 8'd0, 1'b0, "reset");
    step(1'b0, 16'd0, S_IDLE, 8'd0, 1'b0, "reset");
    rst = 1'b0;
    step(1'b0, 16'd0, S_IDLE, 8'd0, 1'b0, "idle_disabled");

    // 1: flush for 4 clocks, acquisition, into TRACK
    enable = 1'b1;
    enter_track(8'd0, 4, 0);

    // 2: eight good strobes lock on the eighth (boundary magnitude 1023 counts as good)
    for (int k = 0; k < 7; k++)
      sym((k == 3) ? 16'hFC01 : 16'd100, S_TRACK, 8'd0, 1'b0, 4, "track_good");
    sym(16'd100, S_LOCKED, 8'd0, 1'b0, 4, "lock");

    // 5: bad run broken by a 4095 strobe, then four bad (4096) drop lock
    for (int k = 0; k < 3; k++) sym(16'h8000, S_LOCKED, 8'd0, 1'b0, 4, "locked_bad");
    sym(16'd4095, S_LOCKED, 8'd0, 1'b0, 4, "locked_clear");
    for (int k = 0; k < 3; k++) sym(16'd4096, S_LOCKED, 8'd0, 1'b0, 4, "locked_bad2");
    sym(16'd4096, S_FLUSH, 8'd0, 1'b1, 4, "lock_lost");
    enter_track(8'd0, 4, 4);

    // 3: a single non-good strobe restarts the good count (1024 is not good)
    for (int k = 0; k < 7; k++) sym(16'd100, S_TRACK, 8'd0, 1'b0, 4, "track_pre");
    sym(16'hF830, S_TRACK, 8'd0, 1'b0, 4, "track_m2000");
    for (int k = 0; k < 7; k++) sym(16'd100, S_TRACK, 8'd0, 1'b0, 4, "track_mid");
    sym(16'd1024, S_TRACK, 8'd0, 1'b0, 4, "track_1024");
    for (int k = 0; k < 7; k++) sym(16'd100, S_TRACK, 8'd0, 1'b0, 4, "track_post");
    sym(16'd100, S_LOCKED, 8'd0, 1'b0, 4, "relock");
    for (int k = 0; k < 3; k++) sym(16'd5000, S_LOCKED, 8'd0, 1'b0, 4, "locked_bad3");
    sym(16'd5000, S_FLUSH, 8'd0, 1'b1, 4, "lock_lost2");
    enter_track(8'd0, 4, 4);

    // 4: timeout after 64 bad strobes, then repeated retries saturate at 255
    for (int k = 0; k < 63; k++) sym(16'd5000, S_TRACK, 8'd0, 1'b0, 4, "timeout_run");
    sym(16'd5000, S_FLUSH, 8'd1, 1'b0, 4, "timeout");
    rc = 8'd1;
    for (int i = 1; i < 300; i++) begin
      enter_track(rc, 1, (i == 1) ? 4 : 1);
      for (int k = 0; k < 63; k++) sym(16'd5000, S_TRACK, rc, 1'b0, 1, "retry_run");
      rc = (rc == 8'hFF) ? 8'hFF : rc + 8'd1;
      sym(16'd5000, S_FLUSH, rc, 1'b0, 1, "retry");
    end
    cmp("retry_saturated", 32'(retry_cnt), 32'd255);

    // 6: enable dropped on the lock-qualifying strobe wins; retry count kept
    enter_track(8'd255, 4, 1);
    for (int k = 0; k < 7; k++) sym(16'd100, S_TRACK, 8'd255, 1'b0, 4, "pre_disable");
    enable = 1'b0;
    step(1'b1, 16'd100, S_IDLE, 8'd255, 1'b0, "disable_on_lock");
    step(1'b0, 16'd0, S_IDLE, 8'd255, 1'b0, "disabled");
    enable = 1'b1;
    enter_track(8'd255, 4, 0);
    for (int k = 0; k < 7; k++) sym(16'd100, S_TRACK, 8'd255, 1'b0, 4, "relock_run");
    sym(16'd100, S_LOCKED, 8'd255, 1'b0, 4, "relock_final");

    // rst in LOCKED returns every output to its reset value, including retry_cnt
    rst = 1'b1;
    enable = 1'b0;
    step(1'b0, 16'd0, S_IDLE, 8'd0, 1'b0, "rst_in_locked");
    rst = 1'b0;
    step(1'b0, 16'd0, S_IDLE, 8'd0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
